// File: rtl/cpu_pc.sv
// Program counter stage for the one-cycle CPU: sequential fetch, jumps,
// one-level call/return through cpu_lr, and a RUN/HALT sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | fetching; strobes resolve by priority HLT>RET>CALL>JMP>JZ
// ST_HALT | PC frozen at the HLT address until PC_RESUME with PC_EN
module cpu_pc #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VEC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PC_EN,
  input  logic             PC_JMP,
  input  logic             PC_JZ,
  input  logic             ZF,
  input  logic             PC_CALL,
  input  logic             PC_RET,
  input  logic             PC_HLT,
  input  logic             PC_RESUME,
  input  logic [WIDTH-1:0] PC_TARGET,
  input  logic [WIDTH-1:0] LR_OUT,
  output logic [WIDTH-1:0] PC_OUT,
  output logic             LR_LD,
  output logic [WIDTH-1:0] LR_DATA,
  output logic             HALTED,
  output logic             PC_WRAP,
  output logic             PC_ERR
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  logic             state_q, state_nxt;
  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic             wrap_q, wrap_nxt;
  logic             err_q, err_nxt;

  logic             run_active;
  logic             resume_go;
  logic [WIDTH-1:0] pc_inc;
  logic             pc_all_ones;
  logic [2:0]       strobe_cnt;
  logic             multi_strobe;
  logic             jz_taken;

  assign run_active  = (state_q == ST_RUN) && PC_EN;
  assign resume_go   = (state_q == ST_HALT) && PC_EN && PC_RESUME;
  assign pc_inc      = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign pc_all_ones = &pc_q;
  assign jz_taken    = PC_JZ && ZF;

  // JZ is counted as a strobe regardless of ZF.
  assign strobe_cnt   = {2'b00, PC_HLT} + {2'b00, PC_RET} + {2'b00, PC_CALL}
                      + {2'b00, PC_JMP} + {2'b00, PC_JZ};
  assign multi_strobe = (strobe_cnt > 3'd1);

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    wrap_nxt  = 1'b0;
    err_nxt   = err_q;
    if (run_active) begin
      if (multi_strobe)
        err_nxt = 1'b1;
      if (PC_HLT) begin
        state_nxt = ST_HALT;
      end else if (PC_RET) begin
        pc_nxt = LR_OUT;
      end else if (PC_CALL || PC_JMP || jz_taken) begin
        pc_nxt = PC_TARGET;
      end else begin
        pc_nxt   = pc_inc;
        wrap_nxt = pc_all_ones;
      end
    end else if (resume_go) begin
      state_nxt = ST_RUN;
      pc_nxt    = pc_inc;
      wrap_nxt  = pc_all_ones;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      pc_q    <= RST_VEC;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      wrap_q  <= wrap_nxt;
      err_q   <= err_nxt;
    end
  end

  // cpu_lr captures LR_DATA on the same edge the PC moves to the target.
  assign LR_LD   = run_active && PC_CALL && !PC_HLT && !PC_RET;
  assign LR_DATA = pc_inc;

  assign PC_OUT  = pc_q;
  assign HALTED  = (state_q == ST_HALT);
  assign PC_WRAP = wrap_q;
  assign PC_ERR  = err_q;

endmodule

// File: tb/tb_cpu_pc.sv
// Scoreboard bench for cpu_pc: stimulus pushes expected results from a
// plain-arithmetic model (including a one-entry cpu_lr); a monitor compares.
module tb_cpu_pc;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PC_EN = 1'b0, PC_JMP = 1'b0, PC_JZ = 1'b0, ZF = 1'b0;
  logic       PC_CALL = 1'b0, PC_RET = 1'b0, PC_HLT = 1'b0, PC_RESUME = 1'b0;
  logic [7:0] PC_TARGET = 8'h00, LR_OUT = 8'h00;
  logic [7:0] PC_OUT, LR_DATA;
  logic       LR_LD, HALTED, PC_WRAP, PC_ERR;

  cpu_pc #(.WIDTH(8), .RST_VEC(8'h00)) dut (
    .CLK(CLK), .RST(RST), .PC_EN(PC_EN), .PC_JMP(PC_JMP), .PC_JZ(PC_JZ),
    .ZF(ZF), .PC_CALL(PC_CALL), .PC_RET(PC_RET), .PC_HLT(PC_HLT),
    .PC_RESUME(PC_RESUME), .PC_TARGET(PC_TARGET), .LR_OUT(LR_OUT),
    .PC_OUT(PC_OUT), .LR_LD(LR_LD), .LR_DATA(LR_DATA), .HALTED(HALTED),
    .PC_WRAP(PC_WRAP), .PC_ERR(PC_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       lr_ld;
    logic [7:0] lr_data;
    logic [7:0] pc;
    logic       halted;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int m_pc   = 0;
  bit m_halt = 0;
  bit m_err  = 0;
  int m_lr   = 0;

  logic       s_lr_ld;
  logic [7:0] s_lr_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // one cycle of stimulus; the model predicts the post-edge state
  task automatic cyc(input bit en, input bit hlt, input bit ret, input bit call,
                     input bit jmp, input bit jz, input bit zf, input bit resume,
                     input int target);
    exp_t e;
    int   nstrobe;
    bit   wrap;
    @(negedge CLK);
    PC_EN = en; PC_HLT = hlt; PC_RET = ret; PC_CALL = call; PC_JMP = jmp;
    PC_JZ = jz; ZF = zf; PC_RESUME = resume; PC_TARGET = 8'(target);
    LR_OUT = 8'(m_lr);
    e.lr_data = 8'((m_pc + 1) % 256);
    e.lr_ld   = !m_halt && en && call && !hlt && !ret;
    nstrobe   = int'(hlt) + int'(ret) + int'(call) + int'(jmp) + int'(jz);
    wrap = 0;
    if (en && !m_halt) begin
      if (nstrobe >= 2) m_err = 1;
      if (hlt)                     m_halt = 1;
      else if (ret)                m_pc = m_lr;
      else if (call || jmp || (jz && zf)) m_pc = target % 256;
      else begin
        wrap = (m_pc == 255);
        m_pc = (m_pc + 1) % 256;
      end
    end else if (en && m_halt && resume) begin
      m_halt = 0;
      wrap = (m_pc == 255);
      m_pc = (m_pc + 1) % 256;
    end
    if (e.lr_ld) m_lr = e.lr_data;
    e.pc = 8'(m_pc); e.halted = m_halt; e.wrap = wrap; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit en);
    cyc(en, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // async reset asserted between edges, checked before any clock edge
  task automatic do_reset();
    @(posedge CLK);
    #2;
    PC_EN = 0; PC_HLT = 0; PC_RET = 0; PC_CALL = 0; PC_JMP = 0; PC_JZ = 0;
    PC_RESUME = 0;
    RST = 1;
    #1;
    chk("rst_pc", 32'(PC_OUT), 32'h00);
    chk("rst_halted", 32'(HALTED), 0);
    chk("rst_wrap", 32'(PC_WRAP), 0);
    chk("rst_err", 32'(PC_ERR), 0);
    @(negedge CLK);
    RST = 0;
    m_pc = 0; m_halt = 0; m_err = 0;
  endtask

  initial begin : sampler
    forever begin
      @(negedge CLK);
      #3;
      s_lr_ld   = LR_LD;
      s_lr_data = LR_DATA;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0 && !RST) begin
        e = exp_q.pop_front();
        chk("lr_ld", 32'(s_lr_ld), 32'(e.lr_ld));
        chk("lr_data", 32'(s_lr_data), 32'(e.lr_data));
        chk("pc_out", 32'(PC_OUT), 32'(e.pc));
        chk("halted", 32'(HALTED), 32'(e.halted));
        chk("pc_wrap", 32'(PC_WRAP), 32'(e.wrap));
        chk("pc_err", 32'(PC_ERR), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int hit_err;
    do_reset();
    repeat (5) idle(1);                          // 00..05
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 8'hA7);          // CALL at 05 -> A7, LR=06
    repeat (2) idle(1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);              // RET -> 06
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 8'h13);          // JZ, ZF=0 -> +1
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 8'h13);          // JZ, ZF=1 -> 13
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 8'hFE);
    repeat (2) idle(1);                          // FF, 00 with wrap
    repeat (3) idle(0);                          // stall
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 8'h00);          // jump to 0: no wrap
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 8'h20);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);              // HLT at 20
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, i[0], 0, 0, 0, 8'h55);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);              // resume needs PC_EN
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);              // -> 21
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);              // resume in RUN ignored
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 8'hFF);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);              // halt at FF
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);              // resume wraps
    idle(1);
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 8'h40);          // conflict: CALL wins, ERR
    repeat (2) idle(1);
    do_reset();

    hit_err = 0;
    for (int i = 0; i < 600; i++) begin
      bit en, hlt, ret, call, jmp, jz, zf, res;
      int tgt;
      en   = ($urandom_range(0, 9) != 0);
      hlt  = ($urandom_range(0, 11) == 0);
      ret  = ($urandom_range(0, 7) == 0);
      call = ($urandom_range(0, 7) == 0);
      jmp  = ($urandom_range(0, 7) == 0);
      jz   = ($urandom_range(0, 7) == 0);
      zf   = $urandom_range(0, 1) != 0;
      res  = ($urandom_range(0, 3) == 0);
      tgt  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(250, 255))
                                         : 32'($urandom_range(0, 255));
      cyc(en, hlt, ret, call, jmp, jz, zf, res, tgt);
      if (m_err && hit_err == 0) hit_err = i;
      if (i == 300) do_reset();
    end
    repeat (3) @(posedge CLK);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
